// File: rtl/iiitb_sipo_pkg.sv
// Shared definitions for the iiitb serial link: the transmitter-side FSM
// states and the default word width used by both iiitb_piso_tx and iiitb_sipo.
package iiitb_sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/iiitb_piso_tx.sv
// Parallel-in serial-out transmitter. A word is parked in a holding register,
// then moved into a shifter and sent LSB first, one bit per clock, framed by
// ser_frame. A waiting word is reloaded on the last bit edge, so consecutive
// frames run back-to-back with no idle gap.
module iiitb_piso_tx
  import iiitb_sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             tx_en,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             word_done,
  output logic             busy
);

  // A one-bit frame still needs a one-bit counter to stay legal.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [WIDTH-1:0] shifter;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             load;
  logic             accept;

  // Decode the last bit of a frame and whether the held word moves into the shifter this cycle.
  always_comb begin
    last_bit = (state == SHIFT) && (cnt == LAST_CNT);
    load     = hold_full && tx_en && ((state == IDLE) || last_bit);
  end

  // Ready depends only on registered state and tx_en, so a word can always slot in behind a transfer.
  assign in_ready  = !hold_full || load;
  assign accept    = in_valid && in_ready;

  assign ser_frame = (state == SHIFT);
  assign ser_out   = (state == SHIFT) ? shifter[0] : 1'b0;
  assign word_done = last_bit;
  assign busy      = hold_full || (state == SHIFT);

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: start a frame on load, stay in SHIFT across a back-to-back reload.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit && !load) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register, shifter and bit counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shifter   <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        hold_reg <= in_data;
      end
      if (accept) begin
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        shifter <= hold_reg;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        shifter <= shifter >> 1;
        cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule
